detect_sequencer: RTL and testbench
===================================

DETECT_SEQUENCER -- requirements
Module: detect_sequencer

Interface
REQ-001 Parameter CONF_THRESH, default 5'd20: confidence at or above which a face is declared.
REQ-002 Parameter TIMEOUT_CYC, default 24'd5_000_000: maximum CLK cycles in RUN before abort.
REQ-003 Parameter FRAME_SKIP, default 3'd0: number of captured frames discarded between detections.
REQ-004 CLK  in  1  system clock (50 MHz); all logic on rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  level; 1 = run detection cycles continuously.
REQ-007 dataready_async  in  1  frame-captured flag from the pixel-clock capture block, asynchronous to CLK.
REQ-008 mask_done  in  1  level from the mask engine; 1 = engine idle, result valid.
REQ-009 confidence_in  in  5  mask-engine score, valid while mask_done=1.
REQ-010 cansend  out  1  grants the capture block permission to overwrite the frame buffer.
REQ-011 mask_start  out  1  one-cycle start pulse to the mask engine.
REQ-012 confidence_out  out  5  last accepted score.
REQ-013 face_found  out  1  last accepted score >= CONF_THRESH.
REQ-014 result_valid  out  1  one-cycle pulse when confidence_out/face_found update.
REQ-015 frame_count  out  8  completed detections, wraps 255->0.
REQ-016 timeout_err  out  1  sticky; set on RUN timeout.
REQ-017 busy  out  1  1 in any state except IDLE.

Function
REQ-018 dataready_async SHALL pass a 2-flop synchronizer; a rising edge is detected with a third flop (rdy_rise), 3-cycle worst-case latency.
REQ-019 FSM states: IDLE, ARM, SKIP, START, RUN, LATCH.
REQ-020 IDLE: cansend=1; enable=1 -> ARM next cycle.
REQ-021 ARM: cansend=1; on rdy_rise -> SKIP if skip_cnt<FRAME_SKIP (skip_cnt++), else -> START (skip_cnt cleared).
REQ-022 SKIP: cansend=1 -> ARM next cycle.
REQ-023 START: cansend=0, mask_start=1 for exactly this one cycle -> RUN; timeout counter cleared.
REQ-024 RUN: cansend=0; counter increments each cycle; mask_done=1 on or after the 2nd RUN cycle -> LATCH (first RUN cycle ignores mask_done to skip a stale done).
REQ-025 RUN: counter == TIMEOUT_CYC-1 with mask_done=0 -> timeout_err=1, -> IDLE, no result update; mask_done and timeout in same cycle: mask_done wins.
REQ-026 LATCH: confidence_out<=confidence_in, face_found<=(confidence_in>=CONF_THRESH, unsigned), result_valid=1 this cycle, frame_count++ -> ARM if enable else IDLE.
REQ-027 enable deassertion SHALL be honoured only in IDLE, ARM, SKIP (-> IDLE next cycle); START/RUN/LATCH run to completion.
REQ-028 cansend SHALL be 0 in START, RUN, LATCH so the frame buffer is stable during mask evaluation.
REQ-029 rdy_rise arriving outside ARM SHALL be discarded (not queued).
REQ-030 Outputs registered except mask_start, result_valid, cansend, busy, decoded from state register.

Reset
REQ-031 RESET=1 at a CLK edge: state=IDLE, skip_cnt=0, timeout counter=0, synchronizer flops=0, confidence_out=0, face_found=0, frame_count=0, timeout_err=0.
REQ-032 Reset-state outputs: cansend=1, mask_start=0, result_valid=0, busy=0.
REQ-033 RESET mid-RUN SHALL abort with no result_valid pulse; mask engine not re-pulsed.
REQ-034 timeout_err SHALL clear only on RESET.

Structure
REQ-035 Shared package detect_pkg holds the state enum (det_state_t), the confidence width (CONF_W=5) and default CONF_THRESH/TIMEOUT_CYC.
REQ-036 One sub-module, sync_edge (2-flop synchronizer plus rising-edge detector), used for dataready_async.

Verification
REQ-037 FRAME_SKIP=0, enable=1, dataready rises, mask_done after 100 cycles with confidence_in=22 -> one mask_start pulse, result_valid pulse, face_found=1, confidence_out=22, frame_count=1.
REQ-038 confidence_in=19 -> face_found=0; confidence_in=20 -> face_found=1 (threshold boundary).
REQ-039 FRAME_SKIP=2 -> mask_start only on 3rd, 6th dataready rise; cansend=1 throughout skips.
REQ-040 TIMEOUT_CYC=50, mask_done held 0 -> timeout_err=1 at RUN cycle 50, state IDLE, frame_count unchanged; mask_done=1 exactly on that cycle -> LATCH, timeout_err=0.
REQ-041 RESET asserted in RUN -> next cycle all REQ-031/032 values, no result_valid.
REQ-042 enable dropped during RUN -> cycle completes, result_valid pulses, then IDLE; 256 detections -> frame_count wraps to 0.

Source files
------------

// File: rtl/detect_pkg.sv
// detect_pkg: shared state encoding, confidence width and default thresholds for the detect sequencer.
package detect_pkg;
  localparam int CONF_W = 5;
  localparam logic [CONF_W-1:0] DEF_CONF_THRESH = 5'd20;
  localparam logic [23:0] DEF_TIMEOUT_CYC = 24'd5_000_000;
  typedef enum logic [2:0] {IDLE, ARM, SKIP, START, RUN, LATCH} det_state_t;
endpackage

// File: rtl/detect_sequencer_if.sv
// detect_sequencer_if: capture-block, mask-engine and result signals of the detect sequencer.
interface detect_sequencer_if;
  import detect_pkg::*;
  logic enable;
  logic dataready_async;
  logic mask_done;
  logic [CONF_W-1:0] confidence_in;
  logic cansend;
  logic mask_start;
  logic [CONF_W-1:0] confidence_out;
  logic face_found;
  logic result_valid;
  logic [7:0] frame_count;
  logic timeout_err;
  logic busy;
  modport slave (
    input enable, dataready_async, mask_done, confidence_in,
    output cansend, mask_start, confidence_out, face_found, result_valid, frame_count, timeout_err, busy
  );
  modport master (
    output enable, dataready_async, mask_done, confidence_in,
    input cansend, mask_start, confidence_out, face_found, result_valid, frame_count, timeout_err, busy
  );
endinterface

// File: rtl/detect_sequencer_sync_edge.sv
// sync_edge: two-flop synchronizer with a third flop for rising-edge detection.
module sync_edge (
  input  logic CLK,
  input  logic RESET,
  input  logic i_async,
  output logic o_rise
);
  logic [2:0] r_sync;
  always_ff @(posedge CLK) r_sync <= RESET ? 3'd0 : {r_sync[1:0], i_async};
  assign o_rise = r_sync[1] & ~r_sync[2];
endmodule

// File: rtl/detect_sequencer.sv
// detect_sequencer: arms on captured frames, runs the mask engine with a timeout and latches its score.
module detect_sequencer
  import detect_pkg::*;
#(
  parameter logic [CONF_W-1:0] CONF_THRESH = DEF_CONF_THRESH,
  parameter logic [23:0] TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter logic [2:0] FRAME_SKIP = 3'd0
) (
  input logic CLK,
  input logic RESET,
  detect_sequencer_if.slave bus
);
  det_state_t r_state;
  logic [2:0] r_skip;
  logic [23:0] r_cnt;
  logic [CONF_W-1:0] r_conf;
  logic r_face;
  logic [7:0] r_frames;
  logic r_timeout;
  logic w_rise;
  sync_edge u_sync (.CLK(CLK), .RESET(RESET), .i_async(bus.dataready_async), .o_rise(w_rise));
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_skip <= 3'd0;
      r_cnt <= 24'd0;
      r_conf <= '0;
      r_face <= 1'b0;
      r_frames <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.enable) r_state <= ARM;
        ARM:
          if (!bus.enable) r_state <= IDLE;
          else if (w_rise) begin
            r_skip <= (r_skip < FRAME_SKIP) ? r_skip + 3'd1 : 3'd0;
            r_state <= (r_skip < FRAME_SKIP) ? SKIP : START;
          end
        SKIP: r_state <= bus.enable ? ARM : IDLE;
        START: begin
          r_cnt <= 24'd0;
          r_state <= RUN;
        end
        RUN: begin
          r_cnt <= r_cnt + 24'd1;
          // the first RUN cycle (count 0) ignores a done left over from the previous job
          if (r_cnt != 24'd0 && bus.mask_done) r_state <= LATCH;
          else if (r_cnt == TIMEOUT_CYC - 24'd1) begin
            r_timeout <= 1'b1;
            r_state <= IDLE;
          end
        end
        LATCH: begin
          r_conf <= bus.confidence_in;
          r_face <= bus.confidence_in >= CONF_THRESH;
          r_frames <= r_frames + 8'd1;
          r_state <= bus.enable ? ARM : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.cansend = r_state == IDLE || r_state == ARM || r_state == SKIP;
  assign bus.mask_start = r_state == START;
  assign bus.result_valid = r_state == LATCH;
  assign bus.busy = r_state != IDLE;
  assign bus.confidence_out = r_conf;
  assign bus.face_found = r_face;
  assign bus.frame_count = r_frames;
  assign bus.timeout_err = r_timeout;
endmodule

// File: tb/tb_detect_sequencer.sv
// tb_detect_sequencer: transaction-level checks of detect_sequencer with random scores and latencies.
module tb_detect_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  detect_sequencer_if ia ();
  detect_sequencer_if ib ();
  detect_sequencer #(.TIMEOUT_CYC(24'd1000)) dut_a (.CLK(clk), .RESET(rst), .bus(ia));
  detect_sequencer #(.TIMEOUT_CYC(24'd50), .FRAME_SKIP(3'd2)) dut_b (.CLK(clk), .RESET(rst), .bus(ib));
  int errs = 0;
  int chks = 0;
  logic [7:0] a_cnt = 8'd0;
  logic [7:0] b_cnt = 8'd0;
  task automatic tick();
    @(negedge clk);
  endtask
  // one frame-ready pulse on A; returns at the START cycle if a start was seen
  task automatic rise_a(output bit seen);
    seen = 1'b0;
    ia.dataready_async = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (i == 3) ia.dataready_async = 1'b0;
      if (ia.mask_start) seen = 1'b1;
    end
    ia.dataready_async = 1'b0;
  endtask
  task automatic finish_a(input logic [4:0] conf, input int lat);
    bit bad = 1'b0;
    bit got = 1'b0;
    ia.confidence_in = conf;
    for (int i = 0; i < lat; i++) begin
      tick();
      if (ia.mask_start || ia.result_valid || ia.cansend) bad = 1'b1;
    end
    ia.mask_done = 1'b1;
    for (int i = 0; i < 5 && !got; i++) begin
      tick();
      got = ia.result_valid;
    end
    ia.mask_done = 1'b0;
    chks++;
    if (bad) begin errs++; $display("FAIL run_quiet_a: got activity during RUN, want none"); end
    chks++;
    if (!got) begin errs++; $display("FAIL result_valid_a: got no pulse within 5 cycles, want pulse"); end
    a_cnt++;
    tick();
    chks++;
    if (ia.confidence_out !== conf) begin errs++; $display("FAIL conf_a: got %0d want %0d", ia.confidence_out, conf); end
    chks++;
    if (ia.face_found !== (int'(conf) >= 20)) begin errs++; $display("FAIL face_a: got %b want %b for conf %0d", ia.face_found, int'(conf) >= 20, conf); end
    chks++;
    if (ia.frame_count !== a_cnt) begin errs++; $display("FAIL count_a: got %0d want %0d", ia.frame_count, a_cnt); end
  endtask
  task automatic detect_a(input logic [4:0] conf, input int lat);
    bit seen;
    rise_a(seen);
    chks++;
    if (!seen) begin errs++; $display("FAIL start_a: got no mask_start, want one"); end
    else finish_a(conf, lat);
  endtask
  task automatic rise_b(output bit seen, output bit cs_ok);
    seen = 1'b0;
    cs_ok = 1'b1;
    ib.dataready_async = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (i == 3) ib.dataready_async = 1'b0;
      if (ib.mask_start) seen = 1'b1;
      else if (!ib.cansend) cs_ok = 1'b0;
    end
    ib.dataready_async = 1'b0;
  endtask
  task automatic start_b(output bit seen);
    bit cs;
    for (int k = 0; k < 3; k++) rise_b(seen, cs);
  endtask
  task automatic finish_b(input int lat);
    bit got = 1'b0;
    repeat (lat) tick();
    ib.mask_done = 1'b1;
    for (int i = 0; i < 5 && !got; i++) begin
      tick();
      got = ib.result_valid;
    end
    ib.mask_done = 1'b0;
    chks++;
    if (!got) begin errs++; $display("FAIL result_valid_b: got no pulse, want pulse"); end
    b_cnt++;
    tick();
    chks++;
    if (ib.frame_count !== b_cnt) begin errs++; $display("FAIL count_b: got %0d want %0d", ib.frame_count, b_cnt); end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    chks++;
    if ({ia.cansend, ia.mask_start, ia.result_valid, ia.busy, ia.confidence_out, ia.face_found, ia.frame_count, ia.timeout_err} !== {1'b1, 18'd0})
      begin errs++; $display("FAIL reset_a: got cs=%b ms=%b rv=%b busy=%b", ia.cansend, ia.mask_start, ia.result_valid, ia.busy); end
    chks++;
    if ({ib.cansend, ib.mask_start, ib.result_valid, ib.busy, ib.confidence_out, ib.face_found, ib.frame_count, ib.timeout_err} !== {1'b1, 18'd0})
      begin errs++; $display("FAIL reset_b: got cs=%b ms=%b rv=%b busy=%b", ib.cansend, ib.mask_start, ib.result_valid, ib.busy); end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_basic();
    ia.enable = 1'b1;
    tick();
    tick();
    chks++;
    if (ia.busy !== 1'b1 || ia.cansend !== 1'b1) begin errs++; $display("FAIL arm_a: got busy=%b cs=%b want 1 1", ia.busy, ia.cansend); end
    detect_a(5'd22, 100);
  endtask
  task automatic test_threshold();
    detect_a(5'd19, 3);
    detect_a(5'd20, 3);
    detect_a(5'd31, 2);
    detect_a(5'd0, 2);
  endtask
  task automatic test_stale_done();
    bit seen;
    ia.mask_done = 1'b1;
    ia.confidence_in = 5'd9;
    rise_a(seen);
    tick();
    chks++;
    if (ia.result_valid !== 1'b0) begin errs++; $display("FAIL stale_run1: got rv=%b want 0", ia.result_valid); end
    tick();
    chks++;
    if (ia.result_valid !== 1'b0) begin errs++; $display("FAIL stale_run2: got rv=%b want 0", ia.result_valid); end
    tick();
    chks++;
    if (ia.result_valid !== 1'b1) begin errs++; $display("FAIL stale_latch: got rv=%b want 1", ia.result_valid); end
    ia.mask_done = 1'b0;
    a_cnt++;
    tick();
    chks++;
    if (ia.frame_count !== a_cnt || ia.confidence_out !== 5'd9) begin errs++; $display("FAIL stale_result: got cnt=%0d conf=%0d want %0d 9", ia.frame_count, ia.confidence_out, a_cnt); end
  endtask
  task automatic test_random();
    for (int n = 0; n < 8; n++) detect_a(5'($urandom_range(0, 31)), int'($urandom_range(1, 40)));
  endtask
  task automatic test_discard();
    bit seen;
    bit extra = 1'b0;
    rise_a(seen);
    chks++;
    if (!seen) begin errs++; $display("FAIL discard_start: got no mask_start, want one"); end
    ia.dataready_async = 1'b1;
    repeat (4) tick();
    ia.dataready_async = 1'b0;
    repeat (10) tick();
    finish_a(5'd12, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ia.mask_start) extra = 1'b1;
    end
    chks++;
    if (extra) begin errs++; $display("FAIL discard: got mask_start from a RUN-time edge, want none"); end
  endtask
  task automatic test_enable_drop();
    bit seen;
    rise_a(seen);
    ia.enable = 1'b0;
    finish_a(5'd25, 5);
    chks++;
    if (ia.busy !== 1'b0 || ia.cansend !== 1'b1) begin errs++; $display("FAIL enable_drop: got busy=%b cs=%b want 0 1", ia.busy, ia.cansend); end
    ia.enable = 1'b1;
    tick();
  endtask
  task automatic test_skip();
    bit seen;
    bit cs;
    ib.enable = 1'b1;
    ib.confidence_in = 5'd7;
    tick();
    for (int i = 0; i < 6; i++) begin
      rise_b(seen, cs);
      chks++;
      if (seen !== (i % 3 == 2)) begin errs++; $display("FAIL skip_start%0d: got %b want %b", i, seen, i % 3 == 2); end
      chks++;
      if (!cs) begin errs++; $display("FAIL skip_cansend%0d: got cansend=0 while skipping, want 1", i); end
      if (seen) finish_b(3);
    end
  endtask
  task automatic test_timeout_boundary();
    bit seen;
    start_b(seen);
    chks++;
    if (!seen) begin errs++; $display("FAIL tb_start: got no mask_start, want one"); end
    repeat (50) tick();
    ib.mask_done = 1'b1;
    tick();
    chks++;
    if (ib.result_valid !== 1'b1 || ib.timeout_err !== 1'b0) begin errs++; $display("FAIL timeout_boundary: got rv=%b terr=%b want 1 0", ib.result_valid, ib.timeout_err); end
    ib.mask_done = 1'b0;
    b_cnt++;
    tick();
    chks++;
    if (ib.frame_count !== b_cnt) begin errs++; $display("FAIL boundary_count: got %0d want %0d", ib.frame_count, b_cnt); end
  endtask
  task automatic test_timeout();
    bit seen;
    bit rv = 1'b0;
    start_b(seen);
    chks++;
    if (!seen) begin errs++; $display("FAIL to_start: got no mask_start, want one"); end
    for (int n = 1; n <= 50; n++) begin
      tick();
      if (ib.result_valid) rv = 1'b1;
    end
    chks++;
    if (ib.busy !== 1'b1 || ib.timeout_err !== 1'b0) begin errs++; $display("FAIL to_cycle50: got busy=%b terr=%b want 1 0", ib.busy, ib.timeout_err); end
    tick();
    chks++;
    if (ib.timeout_err !== 1'b1 || ib.busy !== 1'b0 || rv || ib.result_valid) begin errs++; $display("FAIL timeout: got terr=%b busy=%b rv=%b want 1 0 0", ib.timeout_err, ib.busy, rv); end
    chks++;
    if (ib.frame_count !== b_cnt) begin errs++; $display("FAIL timeout_count: got %0d want %0d", ib.frame_count, b_cnt); end
    tick();
    start_b(seen);
    finish_b(2);
    chks++;
    if (ib.timeout_err !== 1'b1) begin errs++; $display("FAIL timeout_sticky: got %b want 1", ib.timeout_err); end
    ib.enable = 1'b0;
  endtask
  task automatic test_reset_mid_run();
    bit seen;
    bit bad = 1'b0;
    rise_a(seen);
    repeat (5) tick();
    rst = 1'b1;
    ia.mask_done = 1'b1;
    tick();
    chks++;
    if ({ia.cansend, ia.mask_start, ia.result_valid, ia.busy, ia.confidence_out, ia.face_found, ia.frame_count, ia.timeout_err} !== {1'b1, 18'd0})
      begin errs++; $display("FAIL reset_mid_run: got cs=%b ms=%b rv=%b busy=%b cnt=%0d", ia.cansend, ia.mask_start, ia.result_valid, ia.busy, ia.frame_count); end
    rst = 1'b0;
    ia.mask_done = 1'b0;
    a_cnt = 8'd0;
    b_cnt = 8'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ia.mask_start || ia.result_valid) bad = 1'b1;
    end
    chks++;
    if (bad) begin errs++; $display("FAIL reset_quiet: got mask_start/result_valid after reset, want none"); end
  endtask
  task automatic test_wrap();
    for (int n = 0; n < 256; n++) detect_a(5'($urandom_range(0, 31)), int'($urandom_range(1, 3)));
    chks++;
    if (ia.frame_count !== 8'd0) begin errs++; $display("FAIL wrap: got %0d want 0", ia.frame_count); end
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish within time limit, want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    ia.enable = 1'b0; ia.dataready_async = 1'b0; ia.mask_done = 1'b0; ia.confidence_in = 5'd0;
    ib.enable = 1'b0; ib.dataready_async = 1'b0; ib.mask_done = 1'b0; ib.confidence_in = 5'd0;
    test_reset();
    test_basic();
    test_threshold();
    test_stale_done();
    test_random();
    test_discard();
    test_enable_drop();
    test_skip();
    test_timeout_boundary();
    test_timeout();
    test_reset_mid_run();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
